branch_resolve_bp: RTL and testbench
====================================

BRANCH_RESOLVE_BP -- requirements
Module: branch_resolve_bp

Interface
- REQ-001 SHALL provide parameter XLEN, default 32: datapath width of PC, operands and immediate.
- REQ-002 SHALL provide parameter BHT_DEPTH, default 64, power of two >= 4: number of 2-bit counters; IDX_W = log2(BHT_DEPTH).
- REQ-003 SHALL have one clock and an asynchronous active-low reset, named as in the port list below.
- REQ-004 Ports SHALL be:
  - clk  in  1  rising-edge clock
  - rst_n  in  1  asynchronous active-low reset
  - if_pc_in  in  XLEN  fetch PC for prediction lookup
  - if_pred_taken_out  out  1  prediction for if_pc_in
  - ex_valid_in  in  1  EX-stage instruction valid
  - ex_opcode_in  in  7  opcode
  - ex_funct3_in  in  3  funct3
  - ex_pc_in  in  XLEN  instruction PC
  - ex_rs1_in  in  XLEN  rs1 value
  - ex_rs2_in  in  XLEN  rs2 value
  - ex_imm_in  in  XLEN  sign-extended immediate
  - ex_pred_taken_in  in  1  prediction carried from fetch
  - redirect_valid_out  out  1  one-cycle pulse: flush and refetch
  - redirect_pc_out  out  XLEN  refetch address
  - stat_branches_out  out  32  resolved conditional branches (macro-gated)
  - stat_mispred_out  out  32  mispredicted conditional branches (macro-gated)

Function
- REQ-005 Index SHALL be pc[IDX_W+1:2] for both lookup and update.
- REQ-006 if_pred_taken_out SHALL be combinational, equal to counter[idx] bit 1.
- REQ-007 Conditional branch (opcode 1100011) taken condition by funct3:
  - 000 eq
  - 001 ne
  - 100 signed lt
  - 101 signed ge
  - 110 unsigned lt
  - 111 unsigned ge
  - 010/011: not a branch; no redirect, no BHT update, no stat count.
- REQ-008 Branch target SHALL be ex_pc_in + ex_imm_in, modulo 2^XLEN; fall-through SHALL be ex_pc_in + 4, modulo 2^XLEN.
- REQ-009 Branch mispredict SHALL be asserted when actual taken differs from ex_pred_taken_in.
  - Redirect PC = target if actually taken, else fall-through.
- REQ-010 JAL (1101111) SHALL always redirect to ex_pc_in + ex_imm_in.
- REQ-011 JALR (1100111) SHALL always redirect to (ex_rs1_in + ex_imm_in) with bit 0 cleared.
- REQ-012 Neither JAL nor JALR SHALL update the BHT or the stats.
- REQ-013 Redirect outputs SHALL be registered:
  - Latency: exactly one cycle after the ex_valid_in edge.
  - redirect_valid_out pulses for one cycle.
  - redirect_pc_out holds its last value when not valid.
- REQ-014 With ex_valid_in low, no redirect, BHT update or stat change SHALL occur, regardless of other inputs.
- REQ-015 Other opcodes SHALL produce no redirect and no update.
- REQ-016 BHT update SHALL occur on the clock edge of a valid conditional branch:
  - Taken: counter +1, saturating at 11.
  - Not taken: counter -1, saturating at 00.
- REQ-017 Same-cycle lookup and update of the same index SHALL return the pre-update counter; the new value is visible next cycle.
- REQ-018 Back-to-back valid branches SHALL be accepted every cycle, with no stall and no lost update.

Reset
- REQ-019 On rst_n low, asynchronously:
  - all BHT counters = 01 (weakly not taken)
  - redirect_valid_out = 0
  - redirect_pc_out = 0
  - stat counters = 0
- REQ-020 Reset asserted mid-operation SHALL discard any pending redirect; the first valid instruction after release is processed normally.

Configuration
- REQ-021 Macro BRANCH_STATS_EN defined:
  - stat_branches_out increments on every valid conditional branch.
  - stat_mispred_out increments on every valid mispredicted conditional branch.
  - Both counters wrap FFFFFFFF -> 0.
- REQ-022 Macro BRANCH_STATS_EN undefined: both stat outputs SHALL be tied to 0 and no counter logic SHALL be synthesised.

Verification
- REQ-023 After reset, BEQ at pc 0x100, rs1=rs2=5, imm 0x20, pred 0 -> next cycle redirect_valid_out=1, redirect_pc_out=0x120; counter[0x40 & (BHT_DEPTH-1)] = 10.
- REQ-024 BLT rs1=0xFFFFFFFF, rs2=1, pred 1 -> taken, no redirect; the same operands as BLTU, pred 1 -> redirect to pc+4.
- REQ-025 JALR rs1=0x1001, imm 0x10 -> redirect_pc_out=0x1010; BHT unchanged.
- REQ-026 Three taken branches at the same pc -> counter 01->10->11->11 (saturates); if_pred_taken_out=1 from the cycle after the first update.
- REQ-027 rst_n low in the cycle after a mispredicting branch -> redirect_valid_out=0 immediately; BHT back to 01 everywhere.
- REQ-028 With BRANCH_STATS_EN, 5 branches with 2 mispredicts -> stat_branches_out=5, stat_mispred_out=2; without the macro, both read 0.

Source files
------------

// File: rtl/branch_resolve_bp.sv
// Branch resolution with a 2-bit BHT direction predictor and registered redirect.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_resolve_bp #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc_in,
    output logic            if_pred_taken_out,
    input  logic            ex_valid_in,
    input  logic [6:0]      ex_opcode_in,
    input  logic [2:0]      ex_funct3_in,
    input  logic [XLEN-1:0] ex_pc_in,
    input  logic [XLEN-1:0] ex_rs1_in,
    input  logic [XLEN-1:0] ex_rs2_in,
    input  logic [XLEN-1:0] ex_imm_in,
    input  logic            ex_pred_taken_in,
    output logic            redirect_valid_out,
    output logic [XLEN-1:0] redirect_pc_out,
    output logic [31:0]     stat_branches_out,
    output logic [31:0]     stat_mispred_out
);

    localparam int unsigned IDX_W     = $clog2(BHT_DEPTH);
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;

    logic [1:0]      bht [BHT_DEPTH];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;

    logic            is_branch;
    logic            taken;
    logic            mispredict;
    logic            redirect_next;
    logic [XLEN-1:0] redirect_pc_next;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] fall_through;
    logic [XLEN-1:0] jalr_sum;
    logic [1:0]      cnt_next;
    logic            unused_pc_bits;

    assign if_idx            = if_pc_in[IDX_W+1:2];
    assign ex_idx            = ex_pc_in[IDX_W+1:2];
    assign if_pred_taken_out = bht[if_idx][1];
    assign unused_pc_bits    = ^{if_pc_in[XLEN-1:IDX_W+2], if_pc_in[1:0]};

    assign target       = ex_pc_in + ex_imm_in;
    assign fall_through = ex_pc_in + XLEN'(4);
    assign jalr_sum     = ex_rs1_in + ex_imm_in;

    always_comb begin
        taken = 1'b0;
        case (ex_funct3_in)
            3'b000:  taken = (ex_rs1_in == ex_rs2_in);
            3'b001:  taken = (ex_rs1_in != ex_rs2_in);
            3'b100:  taken = ($signed(ex_rs1_in) <  $signed(ex_rs2_in));
            3'b101:  taken = ($signed(ex_rs1_in) >= $signed(ex_rs2_in));
            3'b110:  taken = (ex_rs1_in <  ex_rs2_in);
            3'b111:  taken = (ex_rs1_in >= ex_rs2_in);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        is_branch = ex_valid_in && (ex_opcode_in == OP_BRANCH) &&
                    (ex_funct3_in != 3'b010) && (ex_funct3_in != 3'b011);
        mispredict       = is_branch && (taken != ex_pred_taken_in);
        redirect_next    = 1'b0;
        redirect_pc_next = redirect_pc_out;
        if (mispredict) begin
            redirect_next    = 1'b1;
            redirect_pc_next = taken ? target : fall_through;
        end else if (ex_valid_in && ex_opcode_in == OP_JAL) begin
            redirect_next    = 1'b1;
            redirect_pc_next = target;
        end else if (ex_valid_in && ex_opcode_in == OP_JALR) begin
            redirect_next    = 1'b1;
            redirect_pc_next = {jalr_sum[XLEN-1:1], 1'b0};
        end
    end

    // Saturating 2-bit counter step for the resolving branch's entry.
    always_comb begin
        cnt_next = bht[ex_idx];
        if (taken) begin
            if (bht[ex_idx] != 2'b11) cnt_next = bht[ex_idx] + 2'b01;
        end else begin
            if (bht[ex_idx] != 2'b00) cnt_next = bht[ex_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (is_branch) begin
            bht[ex_idx] <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_out <= 1'b0;
            redirect_pc_out    <= '0;
        end else begin
            redirect_valid_out <= redirect_next;
            redirect_pc_out    <= redirect_pc_next;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] branches_q;
    logic [31:0] mispred_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branches_q <= '0;
            mispred_q  <= '0;
        end else begin
            if (is_branch)  branches_q <= branches_q + 32'd1;
            if (mispredict) mispred_q  <= mispred_q + 32'd1;
        end
    end

    assign stat_branches_out = branches_q;
    assign stat_mispred_out  = mispred_q;
`else
    assign stat_branches_out = '0;
    assign stat_mispred_out  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_bp.sv
// Randomized self-checking bench for branch_resolve_bp against a behavioural model.
// Honours BRANCH_STATS_EN for the expected statistics values.
module tb_branch_resolve_bp;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [XLEN-1:0] if_pc = '0;
    logic            if_pred;
    logic            ex_valid = 1'b0;
    logic [6:0]      ex_opcode = '0;
    logic [2:0]      ex_funct3 = '0;
    logic [XLEN-1:0] ex_pc = '0;
    logic [XLEN-1:0] ex_rs1 = '0;
    logic [XLEN-1:0] ex_rs2 = '0;
    logic [XLEN-1:0] ex_imm = '0;
    logic            ex_pred = 1'b0;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispred;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference state: per-index counter value 0..3, last redirect, stat totals.
    int          m_bht [DEPTH];
    logic        m_rv;
    logic [31:0] m_rpc;
    int unsigned m_br;
    int unsigned m_mis;

    branch_resolve_bp #(.XLEN(XLEN), .BHT_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .if_pc_in           (if_pc),
        .if_pred_taken_out  (if_pred),
        .ex_valid_in        (ex_valid),
        .ex_opcode_in       (ex_opcode),
        .ex_funct3_in       (ex_funct3),
        .ex_pc_in           (ex_pc),
        .ex_rs1_in          (ex_rs1),
        .ex_rs2_in          (ex_rs2),
        .ex_imm_in          (ex_imm),
        .ex_pred_taken_in   (ex_pred),
        .redirect_valid_out (redirect_valid),
        .redirect_pc_out    (redirect_pc),
        .stat_branches_out  (stat_branches),
        .stat_mispred_out   (stat_mispred)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
        m_rv  = 1'b0;
        m_rpc = '0;
        m_br  = 0;
        m_mis = 0;
    endtask

    task automatic check_stats(input string tag);
`ifdef BRANCH_STATS_EN
        check({tag, "_stat_br"},  stat_branches, m_br);
        check({tag, "_stat_mis"}, stat_mispred,  m_mis);
`else
        check({tag, "_stat_br"},  stat_branches, 32'd0);
        check({tag, "_stat_mis"}, stat_mispred,  32'd0);
`endif
    endtask

    // One EX transaction: checks lookup before the edge, redirect one cycle later.
    task automatic step(input string tag, input logic v, input logic [6:0] op,
                        input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic pred,
                        input logic [31:0] fpc);
        logic        tk;
        logic        br;
        longint      sa;
        longint      sb;
        int          k;
        ex_valid = v; ex_opcode = op; ex_funct3 = f3; ex_pc = pc;
        ex_rs1 = a; ex_rs2 = b; ex_imm = imm; ex_pred = pred; if_pc = fpc;
        #1;
        check({tag, "_pred"}, {31'd0, if_pred}, {31'd0, m_bht[idx_of(fpc)] >= 2});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        tk = 1'b0;
        case (f3)
            3'd0: tk = (a == b);
            3'd1: tk = (a != b);
            3'd4: tk = (sa < sb);
            3'd5: tk = (sa >= sb);
            3'd6: tk = (longint'(a) < longint'(b));
            3'd7: tk = (longint'(a) >= longint'(b));
            default: tk = 1'b0;
        endcase
        br   = v && op == 7'h63 && f3 != 3'd2 && f3 != 3'd3;
        m_rv = 1'b0;
        if (br) begin
            k = idx_of(pc);
            m_br++;
            if (tk != pred) begin
                m_mis++;
                m_rv  = 1'b1;
                m_rpc = tk ? pc + imm : pc + 32'd4;
            end
            m_bht[k] = tk ? ((m_bht[k] == 3) ? 3 : m_bht[k] + 1)
                          : ((m_bht[k] == 0) ? 0 : m_bht[k] - 1);
        end else if (v && op == 7'h6f) begin
            m_rv  = 1'b1;
            m_rpc = pc + imm;
        end else if (v && op == 7'h67) begin
            m_rv  = 1'b1;
            m_rpc = (a + imm) & 32'hFFFF_FFFE;
        end
        @(posedge clk);
        #1;
        check({tag, "_rv"}, {31'd0, redirect_valid}, {31'd0, m_rv});
        check({tag, "_rpc"}, redirect_pc, m_rpc);
        check_stats(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_rv", {31'd0, redirect_valid}, 32'd0);
        check("rst_rpc", redirect_pc, 32'd0);
        check_stats("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0]  op;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        int unsigned r;

        model_reset();
        #2;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            if_pc = 32'(i * 4);
            #1;
            check("rst_bht", {31'd0, if_pred}, 32'd0);
        end

        // BEQ taken but predicted not taken; counter at 0x100 becomes 10.
        step("beq", 1, 7'h63, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 0, 32'h100);
        check("beq_rpc_abs", redirect_pc, 32'h120);
        step("beq_after", 0, 7'h63, 3'd0, 32'h100, 0, 0, 0, 0, 32'h100);
        check("beq_ctr10", {31'd0, if_pred}, 32'd1);

        step("blt",  1, 7'h63, 3'd4, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, 1, 32'h300);
        step("bltu", 1, 7'h63, 3'd6, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, 1, 32'h300);
        check("bltu_abs", redirect_pc, 32'h304);
        step("jalr", 1, 7'h67, 3'd0, 32'h400, 32'h1001, 32'd0, 32'h10, 0, 32'h400);
        check("jalr_abs", redirect_pc, 32'h1010);
        step("jal",  1, 7'h6f, 3'd0, 32'h500, 0, 0, 32'hFFFF_FFF0, 0, 32'h500);
        step("f3_2", 1, 7'h63, 3'd2, 32'h600, 1, 1, 32'h8, 0, 32'h600);
        step("inval", 0, 7'h6f, 3'd0, 32'h700, 1, 1, 32'h8, 0, 32'h700);

        for (int i = 0; i < 3; i++)
            step("sat", 1, 7'h63, 3'd1, 32'h200, 32'd1, 32'd2, 32'h8, 1, 32'h200);
        step("sat_look", 0, 7'h00, 3'd0, 32'h200, 0, 0, 0, 0, 32'h200);

        // Mispredicting branch, then reset in the following cycle.
        step("pre_rst", 1, 7'h63, 3'd0, 32'h800, 32'd3, 32'd4, 32'h8, 1, 32'h800);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_rv", {31'd0, redirect_valid}, 32'd0);
        check("mid_rst_rpc", redirect_pc, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            if_pc = 32'(i * 4);
            #1;
            check("mid_rst_bht", {31'd0, if_pred}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Five branches, two mispredicts.
        step("s1", 1, 7'h63, 3'd0, 32'h10, 1, 1, 8, 1, 32'h10);
        step("s2", 1, 7'h63, 3'd0, 32'h14, 1, 2, 8, 0, 32'h14);
        step("s3", 1, 7'h63, 3'd5, 32'h18, 2, 1, 8, 0, 32'h18);
        step("s4", 1, 7'h63, 3'd7, 32'h1c, 0, 1, 8, 1, 32'h1c);
        step("s5", 1, 7'h63, 3'd1, 32'h20, 0, 1, 8, 1, 32'h20);
`ifdef BRANCH_STATS_EN
        check("five_br", stat_branches, 32'd5);
        check("five_mis", stat_mispred, 32'd2);
`else
        check("five_br", stat_branches, 32'd0);
        check("five_mis", stat_mispred, 32'd0);
`endif

        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            op = (r < 6) ? 7'h63 : (r == 6) ? 7'h6f : (r == 7) ? 7'h67 : 7'(($urandom));
            pc = 32'h8000_0000 + ($urandom_range(0, 7) * 4) + ($urandom_range(0, 1) * 32'hFFFF_FF00);
            a  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
            b  = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) != 0) ? $urandom
                                                   : 32'($urandom_range(0, 3)));
            step("rnd", ($urandom_range(0, 4) != 0), op, 3'($urandom), pc, a, b,
                 $urandom, 1'($urandom),
                 ($urandom_range(0, 1) != 0) ? pc : 32'h8000_0000 + ($urandom_range(0, 7) * 4));
            if (n % 150 == 149) begin
                do_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
